// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - op encodings and FSM states shared by the mult/div unit and control unit
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdOpT;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdStateT;

  function automatic logic isDivide(input mdOpT o);
    return o[1];
  endfunction

  function automatic logic isSigned(input mdOpT o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential shift-add multiplier / restoring divider owning HI/LO
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  mdStateT state, stateNext;
  mdOpT opIn;
  logic accept, zeroDiv;
  logic isDivReg, negRes, negRem, divZeroReg;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH-1:0] acc;

  logic sgnA, sgnB;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0] mulSum, divShift;
  logic [WIDTH-1:0] divDiff, quoFix, remFix;
  logic divFits;
  logic [2*WIDTH-1:0] prodFix;

  assign opIn = mdOpT'(op);
  assign sgnA = isSigned(opIn) & a[WIDTH-1];
  assign sgnB = isSigned(opIn) & b[WIDTH-1];
  assign magA = sgnA ? -a : a;
  assign magB = sgnB ? -b : b;

  // Multiply: upper half accumulates, multiplier bits shift out of the low end.
  assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // Divide: upper half holds the partial remainder, quotient bits shift into the low end.
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opnd};
  assign divDiff  = divShift[WIDTH-1:0] - opnd;

  assign prodFix = negRes ? -acc : acc;
  assign quoFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    zeroDiv   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done      = 1'b1;
          div_zero  = divZeroReg;
          stateNext = IDLE;
        end
        if (start) begin
          accept    = 1'b1;
          zeroDiv   = isDivide(opIn) && (b == '0);
          stateNext = zeroDiv ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(1)) stateNext = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      isDivReg   <= 1'b0;
      negRes     <= 1'b0;
      negRem     <= 1'b0;
      divZeroReg <= 1'b0;
      count      <= '0;
      opnd       <= '0;
      acc        <= '0;
      hi         <= '0;
      lo         <= '0;
    end else if (accept) begin
      isDivReg   <= isDivide(opIn);
      divZeroReg <= zeroDiv;
      negRes     <= sgnA ^ sgnB;
      negRem     <= sgnA;
      count      <= CW'(WIDTH);
      opnd       <= isDivide(opIn) ? magB : magA;
      acc        <= {{WIDTH{1'b0}}, (isDivide(opIn) ? magA : magB)};
    end else if (state == RUN) begin
      count <= count - CW'(1);
      if (isDivReg)
        acc <= {(divFits ? divDiff : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divFits};
      else
        acc <= {mulSum, acc[WIDTH-1:1]};
    end else if (state == FIX) begin
      if (isDivReg) begin
        hi <= remFix;
        lo <= quoFix;
      end else begin
        hi <= prodFix[2*WIDTH-1:WIDTH];
        lo <= prodFix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit at WIDTH=32
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;
  localparam int BOUND = 200;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vecT;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
  } expT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int edgeN = 0;
  int busyN = 0;
  logic [31:0] modelHi = '0, modelLo = '0;
  expT sb[$];
  vecT vec[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    edgeN++;
    if (busy) busyN++;
  endtask

  function automatic expT model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    expT e;
    longint sp;
    logic [63:0] up, ua, ub;
    int sa, sbv;
    e.hi = modelHi; e.lo = modelLo; e.dz = 1'b0;
    ua = {32'b0, av}; ub = {32'b0, bv};
    sa = av; sbv = bv;
    case (o)
      2'b00: begin sp = longint'(sa) * longint'(sbv); e.hi = sp[63:32]; e.lo = sp[31:0]; end
      2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
      2'b10: begin
        if (bv == 0) e.dz = 1'b1;
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin e.lo = av; e.hi = 0; end
        else begin e.lo = sa / sbv; e.hi = sa % sbv; end
      end
      default: begin
        if (bv == 0) e.dz = 1'b1;
        else begin e.lo = av / bv; e.hi = av % bv; end
      end
    endcase
    return e;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv, input expT e);
    start = 1'b1; op = o; a = av; b = bv;
    sb.push_back(e);
    modelHi = e.hi; modelLo = e.lo;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edgeN = 0;
    busyN = busy ? 1 : 0;
  endtask

  task automatic finishOp(input string tag, input bit checkDrop);
    expT e;
    while (!done && edgeN < BOUND) tick();
    check({tag, " done seen"}, done, 1'b1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard entry"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, " hi"}, hi, e.hi);
      check({tag, " lo"}, lo, e.lo);
      check({tag, " div_zero"}, div_zero, e.dz);
      check({tag, " done edge"}, edgeN, e.dz ? 0 : LAT);
      check({tag, " busy cycles"}, busyN, e.dz ? 0 : LAT);
    end
    if (checkDrop) begin
      tick();
      check({tag, " done pulse width"}, {done, div_zero}, 2'b00);
    end
  endtask

  initial begin
    expT e;
    int doneCount;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    vec.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vec.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vec.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0});
    vec.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vec.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vec.push_back('{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0});
    vec.push_back('{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001, 32'h0000_0003, 1'b1});
    vec.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    vec.push_back('{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0});
    vec.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
    vec.push_back('{2'b11, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0});
    vec.push_back('{2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});

    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset div_zero", div_zero, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vec.size(); i++) begin
      e.hi = vec[i].hi; e.lo = vec[i].lo; e.dz = vec[i].dz;
      launch(vec[i].op, vec[i].a, vec[i].b, e);
      finishOp($sformatf("vec%0d", i), 1'b1);
    end

    // start pulsed mid-RUN with a zero divisor must be ignored
    e.hi = 32'h0; e.lo = 32'd42; e.dz = 1'b0;
    launch(2'b01, 32'd6, 32'd7, e);
    repeat (5) tick();
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
    tick();
    start = 1'b0; a = 32'd9; b = 32'd9;
    finishOp("ignore-start", 1'b1);

    // back-to-back: second start accepted in the DONE cycle
    launch(2'b00, 32'hFFFF_FFFD, 32'd7, model(2'b00, 32'hFFFF_FFFD, 32'd7));
    finishOp("b2b-first", 1'b0);
    launch(2'b11, 32'd7, 32'd2, model(2'b11, 32'd7, 32'd2));
    finishOp("b2b-second", 1'b1);

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (i == 3) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if (i == 5) rb = 32'h0000_0003;
      launch(ro, ra, rb, model(ro, ra, rb));
      finishOp($sformatf("rand%0d op%0d", i, ro), 1'b1);
    end

    // asynchronous reset mid-RUN abandons the operation
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset hi/lo nonzero", ((hi | lo) != 0), 1'b1);
    reset = 1'b0;
    #1;
    check("midrun reset busy", busy, 1'b0);
    check("midrun reset hi", hi, 32'h0);
    check("midrun reset lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    check("no done/busy after midrun reset", doneCount, 0);
    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
